// File: rtl/servile_ext_txfifo_if.sv
// Bus bundle for the servile ext TX FIFO: Wishbone request/response plus the byte stream.
interface servile_ext_txfifo_if;
  logic [31:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_irq;

  // Initiator side: CPU/mux plus the stream sink
  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_stb, i_tx_ready,
    input  o_wb_rdt, o_wb_ack, o_tx_data, o_tx_valid, o_irq
  );

  // Responder side: the FIFO block
  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_stb, i_tx_ready,
    output o_wb_rdt, o_wb_ack, o_tx_data, o_tx_valid, o_irq
  );
endinterface

// File: rtl/servile_ext_txfifo.sv
// servile ext-port responder: byte TX FIFO behind a 4-word Wishbone register map.
// 0 DATA (push), 1 STATUS, 2 CTRL, 3 reserved. Single-cycle registered ack.
module servile_ext_txfifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter bit FULL_STALL = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  servile_ext_txfifo_if.slave  bus
);
  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic        r_ack;
  logic [31:0] r_rdt;
  logic        r_tx_en, r_irq_en, r_tx_en_eff, r_ovf;

  logic [AW:0] w_level;
  logic        w_empty, w_full, w_valid, w_pop;
  logic [1:0]  w_reg;
  logic        w_req, w_wr, w_data_wr, w_stall, w_acc;
  logic        w_push, w_ovf_set, w_ovf_clr, w_ctrl_wr, w_flush;
  logic [31:0] w_rd_val;
  logic        w_unused;

  // FIFO state, all from registers
  assign w_level = r_wr - r_rd;
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

  // Stream side: offer head byte while effective enable is on
  assign w_valid = r_tx_en_eff & ~w_empty;
  assign w_pop   = w_valid & bus.i_tx_ready;

  // Request decode; a new request is only looked at while not acking
  assign w_reg     = bus.i_wb_adr[3:2];
  assign w_req     = bus.i_wb_stb & ~r_ack;
  assign w_wr      = bus.i_wb_we & bus.i_wb_sel[0];
  assign w_data_wr = w_wr & (w_reg == A_DATA);
  // Full is judged on registered level, so a same-edge pop does not let a push in
  assign w_stall   = FULL_STALL & w_data_wr & w_full;
  assign w_acc     = w_req & ~w_stall;

  assign w_push    = w_acc & w_data_wr & ~w_full;
  assign w_ovf_set = w_acc & w_data_wr & w_full;
  assign w_ovf_clr = w_acc & w_wr & (w_reg == A_STAT) & bus.i_wb_dat[2];
  assign w_ctrl_wr = w_acc & w_wr & (w_reg == A_CTRL);
  assign w_flush   = w_ctrl_wr & bus.i_wb_dat[2];

  // Address bits above [3:2], upper data and upper byte enables carry no meaning here
  assign w_unused = ^{bus.i_wb_adr[31:4], bus.i_wb_adr[1:0], bus.i_wb_dat[31:8], bus.i_wb_sel[3:1]};

  // Read mux; writes return zero
  always_comb begin
    w_rd_val = '0;
    if (!bus.i_wb_we) begin
      case (w_reg)
        A_STAT:  w_rd_val = {16'd0, 8'(w_level), 4'd0, r_tx_en_eff, r_ovf, w_full, w_empty};
        A_CTRL:  w_rd_val = {30'd0, r_irq_en, r_tx_en};
        default: w_rd_val = '0;
      endcase
    end
  end

  // Storage array, no reset needed: contents are only visible through the pointers
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= bus.i_wb_dat[7:0];
  end

  // Pointers: flush collapses to empty and overrides any pop on the same edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (w_flush) begin
      r_rd <= r_wr;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_ONE;
      if (w_pop)  r_rd <= r_rd + PTR_ONE;
    end
  end

  // Wishbone response: one-cycle ack with read data, zero otherwise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack <= 1'b0;
      r_rdt <= '0;
    end else begin
      r_ack <= w_acc;
      r_rdt <= w_acc ? w_rd_val : 32'd0;
    end
  end

  // Control/status registers; tx_en_eff waits while a byte is offered but not taken
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_en     <= 1'b1;
      r_irq_en    <= 1'b0;
      r_tx_en_eff <= 1'b1;
      r_ovf       <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_tx_en  <= bus.i_wb_dat[0];
        r_irq_en <= bus.i_wb_dat[1];
      end
      if (!(w_valid && !bus.i_tx_ready)) r_tx_en_eff <= r_tx_en;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign bus.o_wb_ack   = r_ack;
  assign bus.o_wb_rdt   = r_rdt;
  assign bus.o_tx_valid = w_valid;
  assign bus.o_tx_data  = r_mem[r_rd[AW-1:0]];
  assign bus.o_irq      = r_irq_en & w_empty;
endmodule

// File: tb/tb_servile_ext_txfifo.sv
// Bench for servile_ext_txfifo: queue-based model on dut0 (stalling) checked every cycle,
// directed literal checks on both dut0 and dut1 (dropping, FULL_STALL=0).
module tb_servile_ext_txfifo;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam bit FS0   = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  servile_ext_txfifo_if bus0();
  servile_ext_txfifo_if bus1();

  servile_ext_txfifo #(.DEPTH_LOG2(DL2), .FULL_STALL(1'b1)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0.slave));
  servile_ext_txfifo #(.DEPTH_LOG2(DL2), .FULL_STALL(1'b0)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model of dut0: byte queue plus control bits ----------------
  logic [7:0]  mq[$];
  bit          m_tx_en = 1, m_irq_en = 0, m_eff = 1, m_ovf = 0, m_ack = 0;
  logic [31:0] m_rdt = 0;
  bit          mm_vld, mm_pop, mm_full, mm_wr, mm_req, mm_acc, mm_eff;
  logic [1:0]  mm_reg;
  logic [31:0] mm_rdt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_tx_en = 1; m_irq_en = 0; m_eff = 1; m_ovf = 0; m_ack = 0; m_rdt = 0;
    end else begin
      mm_vld  = m_eff && mq.size() != 0;
      mm_pop  = mm_vld && bus0.i_tx_ready;
      mm_full = mq.size() == DEPTH;
      mm_reg  = bus0.i_wb_adr[3:2];
      mm_wr   = bus0.i_wb_we && bus0.i_wb_sel[0];
      mm_req  = bus0.i_wb_stb && !m_ack;
      mm_acc  = mm_req && !(FS0 && mm_wr && mm_reg == 0 && mm_full);
      mm_rdt  = 0;
      if (mm_acc && !bus0.i_wb_we) begin
        if (mm_reg == 1)
          mm_rdt = {16'd0, 8'(mq.size()), 4'd0, m_eff, m_ovf, mm_full, mq.size() == 0};
        else if (mm_reg == 2)
          mm_rdt = {30'd0, m_irq_en, m_tx_en};
      end
      mm_eff = (mm_vld && !bus0.i_tx_ready) ? m_eff : m_tx_en;
      if (mm_acc && mm_wr && mm_reg == 2 && bus0.i_wb_dat[2]) mq.delete();
      else begin
        if (mm_pop) void'(mq.pop_front());
        if (mm_acc && mm_wr && mm_reg == 0 && !mm_full) mq.push_back(bus0.i_wb_dat[7:0]);
      end
      if (mm_acc && mm_wr && mm_reg == 0 && mm_full) m_ovf = 1;
      if (mm_acc && mm_wr && mm_reg == 1 && bus0.i_wb_dat[2]) m_ovf = 0;
      if (mm_acc && mm_wr && mm_reg == 2) begin
        m_tx_en  = bus0.i_wb_dat[0];
        m_irq_en = bus0.i_wb_dat[1];
      end
      m_eff = mm_eff;
      m_ack = mm_acc;
      m_rdt = mm_rdt;
    end
  end

  // Every-cycle compare of dut0 against the model, mid-cycle
  always @(negedge clk) begin
    chk("m_ack",   {31'd0, bus0.o_wb_ack},   {31'd0, m_ack});
    chk("m_rdt",   bus0.o_wb_rdt,            m_rdt);
    chk("m_valid", {31'd0, bus0.o_tx_valid}, {31'd0, m_eff && mq.size() != 0});
    if (m_eff && mq.size() != 0) chk("m_data", {24'd0, bus0.o_tx_data}, {24'd0, mq[0]});
    chk("m_irq",   {31'd0, bus0.o_irq},      {31'd0, m_irq_en && mq.size() == 0});
  end

  // Stream capture (transfer decided at the coming edge; inputs only move just after edges)
  logic [7:0] got0[$];
  logic [7:0] got1[$];
  always @(negedge clk) begin
    if (!rst && bus0.o_tx_valid && bus0.i_tx_ready) got0.push_back(bus0.o_tx_data);
    if (!rst && bus1.o_tx_valid && bus1.i_tx_ready) got1.push_back(bus1.o_tx_data);
  end

  // ---------------- bus helpers ----------------
  task automatic drv(input bit d, input bit stb, input bit we, input logic [1:0] a,
                     input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] adr;
    adr = 32'h4000_0000 | {28'd0, a, 2'b00};
    if (d) begin
      bus1.i_wb_stb = stb; bus1.i_wb_we = we; bus1.i_wb_adr = adr; bus1.i_wb_dat = dat; bus1.i_wb_sel = sel;
    end else begin
      bus0.i_wb_stb = stb; bus0.i_wb_we = we; bus0.i_wb_adr = adr; bus0.i_wb_dat = dat; bus0.i_wb_sel = sel;
    end
  endtask

  task automatic wb(input bit d, input bit we, input logic [1:0] a, input logic [31:0] dat,
                    output logic [31:0] rd, output int lat);
    @(negedge clk);
    while (d ? bus1.o_wb_ack : bus0.o_wb_ack) @(negedge clk);
    drv(d, 1'b1, we, a, dat, 4'hF);
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (d ? bus1.o_wb_ack : bus0.o_wb_ack) begin
        lat = i;
        rd  = d ? bus1.o_wb_rdt : bus0.o_wb_rdt;
        break;
      end
    end
    drv(d, 1'b0, 1'b0, 2'd0, 32'd0, 4'h0);
  endtask

  task automatic wr(input bit d, input logic [1:0] a, input logic [31:0] dat, input string nm);
    logic [31:0] rd;
    int lat;
    wb(d, 1'b1, a, dat, rd, lat);
    chk({nm, "_lat"}, lat, 1);
  endtask

  task automatic rdchk(input bit d, input logic [1:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] rd;
    int lat;
    wb(d, 1'b0, a, 32'd0, rd, lat);
    chk({nm, "_lat"}, lat, 1);
    chk(nm, rd, exp);
  endtask

  logic [7:0] exp0[$];

  initial begin
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    bus0.i_tx_ready = 1'b1;
    bus1.i_tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",   {31'd0, bus0.o_wb_ack},   0);
    chk("rst_valid", {31'd0, bus0.o_tx_valid}, 0);
    chk("rst_irq",   {31'd0, bus0.o_irq},      0);
    @(negedge clk) rst = 1'b0;

    // T1: three bytes straight through
    wr(0, 2'd0, 32'h41, "t1_w41");
    wr(0, 2'd0, 32'h42, "t1_w42");
    wr(0, 2'd0, 32'h43, "t1_w43");
    repeat (4) @(posedge clk);
    rdchk(0, 2'd1, 32'h0000_0009, "t1_status");
    exp0 = {8'h41, 8'h42, 8'h43};

    // T2: fill, stall the 17th, one pop lets it in two edges later
    @(posedge clk); #1 bus0.i_tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr(0, 2'd0, i, "t2_fill");
    rdchk(0, 2'd1, 32'h0000_100A, "t2_status_full");
    @(negedge clk);
    while (bus0.o_wb_ack) @(negedge clk);
    drv(0, 1'b1, 1'b1, 2'd0, 32'hAA, 4'hF);
    repeat (3) begin @(posedge clk); #1; chk("t2_stall", {31'd0, bus0.o_wb_ack}, 0); end
    bus0.i_tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_no_ack_on_pop_edge", {31'd0, bus0.o_wb_ack}, 0);
    bus0.i_tx_ready = 1'b0;
    @(posedge clk); #1;
    chk("t2_ack_after", {31'd0, bus0.o_wb_ack}, 1);
    drv(0, 0, 0, 0, 0, 0);
    bus0.i_tx_ready = 1'b1;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 16; i++) exp0.push_back(8'(i));
    exp0.push_back(8'hAA);

    // T3: clearing tx_en does not withdraw an offered byte
    #1 bus0.i_tx_ready = 1'b0;
    wr(0, 2'd0, 32'h55, "t3_w55");
    wr(0, 2'd0, 32'h66, "t3_w66");
    wr(0, 2'd0, 32'h77, "t3_w77");
    wr(0, 2'd2, 32'h0, "t3_ctrl0");
    repeat (2) begin
      @(posedge clk); #1;
      chk("t3_hold_valid", {31'd0, bus0.o_tx_valid}, 1);
      chk("t3_hold_data",  {24'd0, bus0.o_tx_data},  32'h55);
    end
    bus0.i_tx_ready = 1'b1;
    @(posedge clk); #1;
    bus0.i_tx_ready = 1'b0;
    chk("t3_valid_off", {31'd0, bus0.o_tx_valid}, 0);
    rdchk(0, 2'd1, 32'h0000_0200, "t3_status");
    exp0.push_back(8'h55);

    // T4: flush drops a pending offer and empties the FIFO
    wr(0, 2'd2, 32'h1, "t4_ctrl1");
    wr(0, 2'd0, 32'h88, "t4_w88");
    wr(0, 2'd0, 32'h89, "t4_w89");
    wr(0, 2'd0, 32'h8A, "t4_w8a");
    chk("t4_valid_on", {31'd0, bus0.o_tx_valid}, 1);
    chk("t4_head",     {24'd0, bus0.o_tx_data},  32'h66);
    wr(0, 2'd2, 32'h5, "t4_flush");
    chk("t4_valid_flush", {31'd0, bus0.o_tx_valid}, 0);
    rdchk(0, 2'd1, 32'h0000_0009, "t4_status");
    rdchk(0, 2'd2, 32'h0000_0001, "t4_ctrl_rd");

    // T5: irq follows irq_en & empty
    wr(0, 2'd2, 32'h3, "t5_ctrl3");
    chk("t5_irq_idle", {31'd0, bus0.o_irq}, 1);
    bus0.i_tx_ready = 1'b1;
    wr(0, 2'd0, 32'h99, "t5_w99");
    chk("t5_irq_fall", {31'd0, bus0.o_irq}, 0);
    @(posedge clk); #1;
    chk("t5_irq_rise", {31'd0, bus0.o_irq}, 1);
    exp0.push_back(8'h99);

    // T6: reset during a stalled write
    bus0.i_tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr(0, 2'd0, 32'hC0 + i, "t6_fill");
    @(negedge clk);
    while (bus0.o_wb_ack) @(negedge clk);
    drv(0, 1'b1, 1'b1, 2'd0, 32'hDD, 4'hF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_ack",   {31'd0, bus0.o_wb_ack},   0);
    chk("t6_valid", {31'd0, bus0.o_tx_valid}, 0);
    chk("t6_irq",   {31'd0, bus0.o_irq},      0);
    repeat (3) begin @(posedge clk); #1; chk("t6_ack_in_rst", {31'd0, bus0.o_wb_ack}, 0); end
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    rdchk(0, 2'd1, 32'h0000_0009, "t6_status");
    rdchk(0, 2'd2, 32'h0000_0001, "t6_ctrl");

    // dut1 (drop on full): 17th acked at once, OVF sticky until cleared
    for (int i = 0; i < 16; i++) wr(1, 2'd0, 32'h10 + i, "d1_fill");
    wr(1, 2'd0, 32'hEE, "d1_w17");
    rdchk(1, 2'd1, 32'h0000_100E, "d1_status_ovf");
    wr(1, 2'd3, 32'hFF, "d1_reserved");
    rdchk(1, 2'd3, 32'h0000_0000, "d1_reserved_rd");
    rdchk(1, 2'd1, 32'h0000_100E, "d1_status_still");
    wr(1, 2'd1, 32'h4, "d1_clr_ovf");
    rdchk(1, 2'd1, 32'h0000_100A, "d1_status_clr");
    bus1.i_tx_ready = 1'b1;
    repeat (25) @(posedge clk);

    // Stream contents and order
    chk("got0_len", got0.size(), exp0.size());
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) chk("got0_byte", {24'd0, got0[i]}, {24'd0, exp0[i]});
    chk("got1_len", got1.size(), 16);
    for (int i = 0; i < 16 && i < got1.size(); i++) chk("got1_byte", {24'd0, got1[i]}, 32'h10 + i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
